clock_period_meter: RTL

//  Measuring counterpart of clock_divider: takes an external or divided clock-like

---
 rtl/clock_period_meter.sv | 99 +++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous clock-like input in clk cycles.
// Results update on each rising edge of the synchronised input; saturated intervals are discarded.
module clock_period_meter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sig_in,
    output logic [BITS-1:0] period,
    output logic [BITS-1:0] high_time,
    output logic            valid,
    output logic            overflow,
    output logic            locked
);

    typedef enum logic {IDLE, MEASURE} state_e;

    localparam logic [BITS-1:0] CNT_MAX = '1;

    state_e          state_q;
    logic [BITS-1:0] cnt_q, period_q, high_q, hicap_q;
    logic            valid_q, ovf_q, locked_q, sat_q;
    logic            s1_q, s2_q, d_q;
    logic            rise, fall;

    assign rise = s2_q & ~d_q;
    assign fall = ~s2_q & d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            hicap_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            d_q      <= 1'b0;
        end else begin
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            d_q     <= s2_q;
            valid_q <= 1'b0;
            if (!en) begin
                // Disable abandons the interval in flight; last results stay visible.
                state_q  <= IDLE;
                cnt_q    <= '0;
                sat_q    <= 1'b0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            cnt_q   <= BITS'(1);
                        end
                    end
                    MEASURE: begin
                        if (fall)
                            hicap_q <= cnt_q;
                        if (rise) begin
                            cnt_q <= BITS'(1);
                            sat_q <= 1'b0;
                            if (!sat_q) begin
                                period_q <= cnt_q;
                                high_q   <= hicap_q;
                                valid_q  <= 1'b1;
                                ovf_q    <= 1'b0;
                                locked_q <= (cnt_q == period_q) && (hicap_q == high_q);
                            end else begin
                                locked_q <= 1'b0;
                            end
                        end else if (cnt_q == CNT_MAX) begin
                            // A rise landing exactly on CNT_MAX is still a good measurement,
                            // so saturation is only flagged once the count would go past it.
                            sat_q <= 1'b1;
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;
    assign locked    = locked_q;

endmodule
